// File: rtl/turn_sequencer.sv
// Per-turn shot sequencer: range-checks a fire request, then reads and writes back the opponent cell.
// It also tracks hits, declares the winner and passes the turn. TURN_TIMEOUT_EN adds idle-turn forfeiting.
module turn_sequencer #(
  parameter int BOARD_SIZE     = 10,
  parameter int SHIP_CELLS     = 17,
  parameter int TIMEOUT_CYCLES = 810000000
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       fire,
  input  logic [3:0] shot_row,
  input  logic [3:0] shot_col,
  input  logic       new_game,
  output logic       brd_req,
  output logic       brd_we,
  output logic       brd_player,
  output logic [3:0] brd_row,
  output logic [3:0] brd_col,
  output logic [1:0] brd_wdata,
  input  logic       brd_gnt,
  input  logic [1:0] brd_rdata,
  output logic       player_turn,
  output logic       busy,
  output logic       shot_hit,
  output logic       shot_miss,
  output logic       shot_reject,
  output logic [6:0] hits_p1,
  output logic [6:0] hits_p2,
  output logic       game_over,
  output logic       winner,
  output logic       turn_timeout
);

  localparam logic [3:0] BOARD_LIMIT = 4'(BOARD_SIZE);
  localparam logic [6:0] SHIP_TARGET = 7'(SHIP_CELLS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    SWITCH = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       req_d, we_d, player_d, turn_d, busy_d;
  logic       hit_d, miss_d, rej_d, over_d, winner_d, tmo_d;
  logic [3:0] row_d, col_d;
  logic [1:0] wdata_d;
  logic [6:0] hits1_d, hits2_d, hits_cur, hits_inc;
  logic       timeout_hit;

`ifdef TURN_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (idle_cnt_q == TIMEOUT_LAST);

  // Any request seen in IDLE restarts the idle window so the compare cannot be stepped over.
  always_comb begin
    idle_cnt_d = 32'd0;
    if (state_q == IDLE && state_d == IDLE && !fire && !new_game)
      idle_cnt_d = idle_cnt_q + 32'd1;
  end

  always_ff @(posedge clock27) begin
    if (reset) idle_cnt_q <= 32'd0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  assign hits_cur = player_turn ? hits_p2 : hits_p1;
  assign hits_inc = (hits_cur == 7'd127) ? hits_cur : hits_cur + 7'd1;

  always_comb begin
    state_d  = state_q;
    req_d    = brd_req;
    we_d     = brd_we;
    player_d = brd_player;
    row_d    = brd_row;
    col_d    = brd_col;
    wdata_d  = brd_wdata;
    turn_d   = player_turn;
    hits1_d  = hits_p1;
    hits2_d  = hits_p2;
    over_d   = game_over;
    winner_d = winner;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    rej_d    = 1'b0;
    tmo_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (new_game) begin
          hits1_d  = 7'd0;
          hits2_d  = 7'd0;
          over_d   = 1'b0;
          winner_d = 1'b0;
          turn_d   = 1'b0;
        end else if (fire) begin
          if (shot_row < BOARD_LIMIT && shot_col < BOARD_LIMIT) begin
            row_d    = shot_row;
            col_d    = shot_col;
            player_d = ~player_turn;
            req_d    = 1'b1;
            we_d     = 1'b0;
            state_d  = READ;
          end else begin
            rej_d = 1'b1;
          end
        end else if (timeout_hit) begin
          tmo_d   = 1'b1;
          state_d = SWITCH;
        end
      end

      READ: begin
        if (brd_gnt) begin
          if (brd_rdata[1]) begin
            rej_d   = 1'b1;
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            // 00 water -> 10 miss, 01 ship -> 11 hit
            wdata_d = {1'b1, brd_rdata[0]};
            we_d    = 1'b1;
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        if (brd_gnt) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = SWITCH;
          if (brd_wdata[0]) begin
            hit_d = 1'b1;
            if (player_turn) hits2_d = hits_inc;
            else             hits1_d = hits_inc;
            if (hits_inc == SHIP_TARGET) begin
              over_d   = 1'b1;
              winner_d = player_turn;
              state_d  = OVER;
            end
          end else begin
            miss_d = 1'b1;
          end
        end
      end

      SWITCH: begin
        turn_d  = ~player_turn;
        state_d = IDLE;
      end

      OVER: begin
        if (new_game) begin
          hits1_d  = 7'd0;
          hits2_d  = 7'd0;
          over_d   = 1'b0;
          winner_d = 1'b0;
          turn_d   = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock27) begin
    if (reset) begin
      state_q      <= IDLE;
      brd_req      <= 1'b0;
      brd_we       <= 1'b0;
      brd_player   <= 1'b0;
      brd_row      <= 4'd0;
      brd_col      <= 4'd0;
      brd_wdata    <= 2'd0;
      player_turn  <= 1'b0;
      busy         <= 1'b0;
      shot_hit     <= 1'b0;
      shot_miss    <= 1'b0;
      shot_reject  <= 1'b0;
      hits_p1      <= 7'd0;
      hits_p2      <= 7'd0;
      game_over    <= 1'b0;
      winner       <= 1'b0;
      turn_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      brd_req      <= req_d;
      brd_we       <= we_d;
      brd_player   <= player_d;
      brd_row      <= row_d;
      brd_col      <= col_d;
      brd_wdata    <= wdata_d;
      player_turn  <= turn_d;
      busy         <= busy_d;
      shot_hit     <= hit_d;
      shot_miss    <= miss_d;
      shot_reject  <= rej_d;
      hits_p1      <= hits1_d;
      hits_p2      <= hits2_d;
      game_over    <= over_d;
      winner       <= winner_d;
      turn_timeout <= tmo_d;
    end
  end

endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer: directed shots push expected events, a monitor checks every pulse.
module tb_turn_sequencer;
  localparam logic [3:0] P_HIT  = 4'b1000;
  localparam logic [3:0] P_MISS = 4'b0100;
  localparam logic [3:0] P_REJ  = 4'b0010;
  localparam logic [3:0] P_TMO  = 4'b0001;

  logic       clock27 = 1'b0;
  logic       reset, fire, new_game, brd_gnt;
  logic [3:0] shot_row, shot_col;
  logic       brd_req, brd_we, brd_player;
  logic [3:0] brd_row, brd_col;
  logic [1:0] brd_wdata, brd_rdata;
  logic       player_turn, busy, shot_hit, shot_miss, shot_reject;
  logic [6:0] hits_p1, hits_p2;
  logic       game_over, winner, turn_timeout;

  always #5 clock27 = ~clock27;

  turn_sequencer #(.BOARD_SIZE(10), .SHIP_CELLS(17), .TIMEOUT_CYCLES(8)) dut (
    .clock27(clock27), .reset(reset), .fire(fire), .shot_row(shot_row), .shot_col(shot_col),
    .new_game(new_game), .brd_req(brd_req), .brd_we(brd_we), .brd_player(brd_player),
    .brd_row(brd_row), .brd_col(brd_col), .brd_wdata(brd_wdata), .brd_gnt(brd_gnt),
    .brd_rdata(brd_rdata), .player_turn(player_turn), .busy(busy), .shot_hit(shot_hit),
    .shot_miss(shot_miss), .shot_reject(shot_reject), .hits_p1(hits_p1), .hits_p2(hits_p2),
    .game_over(game_over), .winner(winner), .turn_timeout(turn_timeout)
  );

  // Board memory model: two 16x16 planes so any 4-bit address is safe.
  logic [1:0] board [0:1][0:15][0:15];
  int         wr_count = 0;

  assign brd_rdata = board[brd_player][brd_row][brd_col];

  always @(posedge clock27) begin
    if (brd_req && brd_gnt && brd_we) begin
      board[brd_player][brd_row][brd_col] = brd_wdata;
      wr_count = wr_count + 1;
    end
  end

  typedef struct packed {
    logic [3:0] pulses;
    logic [6:0] h1;
    logic [6:0] h2;
    logic       over;
    logic       win;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  exp_t       mon_e;
  logic [3:0] mon_got;

  always @(negedge clock27) begin
    mon_got = {shot_hit, shot_miss, shot_reject, turn_timeout};
    if (mon_got != 4'b0000) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_event got=%b hits=%0d/%0d", mon_got, hits_p1, hits_p2);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got !== mon_e.pulses || hits_p1 !== mon_e.h1 || hits_p2 !== mon_e.h2 ||
            game_over !== mon_e.over || (mon_e.over && winner !== mon_e.win)) begin
          failures = failures + 1;
          $display("FAIL event got=%b h1=%0d h2=%0d over=%b win=%b exp=%b h1=%0d h2=%0d over=%b win=%b",
                   mon_got, hits_p1, hits_p2, game_over, winner,
                   mon_e.pulses, mon_e.h1, mon_e.h2, mon_e.over, mon_e.win);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  task automatic expect_evt(input logic [3:0] p, input int h1, input int h2, input logic over);
    exp_t e;
    e.pulses = p;
    e.h1     = 7'(h1);
    e.h2     = 7'(h2);
    e.over   = over;
    e.win    = 1'b0;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the following negedge with fire low again.
  task automatic fire_shot(input int r, input int c);
    shot_row = 4'(r);
    shot_col = 4'(c);
    fire     = 1'b1;
    @(negedge clock27);
    fire = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && !game_over && n < 60) begin
      @(negedge clock27);
      n++;
    end
    chk(name, 32'(n < 60), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int   wc;
  logic tmo_seen;

  initial begin
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          board[p][r][c] = 2'b00;
    board[1][2][3] = 2'b01;
    board[0][0][0] = 2'b10;
    for (int i = 0; i < 16; i++) board[1][5 + i / 10][i % 10] = 2'b01;
    board[1][9][0] = 2'b01;

    reset = 1'b1; fire = 1'b0; new_game = 1'b0; brd_gnt = 1'b1;
    shot_row = 4'd0; shot_col = 4'd0;
    repeat (3) @(negedge clock27);
    chk("reset_port", {brd_req, brd_we, brd_player, brd_row, brd_col, brd_wdata}, 32'd0);
    chk("reset_status", {player_turn, busy, shot_hit, shot_miss, shot_reject, hits_p1, hits_p2,
                         game_over, winner, turn_timeout}, 32'd0);
    reset = 1'b0;

    // Hit at (2,3): latency T+1 read, T+2 write, T+3 pulse, T+4 turn change
    expect_evt(P_HIT, 1, 0, 1'b0);
    fire_shot(2, 3);
    chk("t1_read", {brd_req, brd_we, brd_player, brd_row, brd_col}, {21'd0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd3});
    @(negedge clock27);
    chk("t2_write", {brd_req, brd_we, brd_wdata}, 32'b1111);
    @(negedge clock27);
    chk("t3_req_drop", {brd_req, player_turn}, 32'd0);
    @(negedge clock27);
    chk("t4_turn", {player_turn, busy}, 32'b10);
    chk("hit_written", board[1][2][3], 32'd3);
    chk("hit_wr_count", wr_count, 32'd1);

    // Already-shot cell: read only, reject, turn kept
    wc = wr_count;
    expect_evt(P_REJ, 1, 0, 1'b0);
    fire_shot(0, 0);
    wait_idle("dup_idle");
    chk("dup_no_write", wr_count, wc);
    chk("dup_turn", player_turn, 32'd1);

    // Out-of-range coordinates
    expect_evt(P_REJ, 1, 0, 1'b0);
    fire_shot(10, 4);
    chk("oor_row_idle", {brd_req, busy}, 32'd0);
    expect_evt(P_REJ, 1, 0, 1'b0);
    fire_shot(3, 10);
    chk("oor_col_idle", {brd_req, busy, player_turn}, 32'b001);

    // Grant stall with a stray fire in the middle
    brd_gnt = 1'b0;
    expect_evt(P_MISS, 1, 0, 1'b0);
    fire_shot(5, 6);
    chk("stall_issue", {brd_req, brd_we, brd_player, brd_row, brd_col}, {21'd0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6});
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin shot_row = 4'd1; shot_col = 4'd1; fire = 1'b1; end
      @(negedge clock27);
      fire = 1'b0;
      chk("stall_hold", {brd_req, brd_we, brd_player, brd_row, brd_col}, {21'd0, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6});
    end
    brd_gnt = 1'b1;
    wait_idle("stall_idle");
    chk("stall_turn", player_turn, 32'd0);
    chk("stall_written", board[0][5][6], 32'd2);
    chk("stray_not_read", board[0][1][1], 32'd0);

    // Player one to 17 hits, player two misses in between
    for (int i = 0; i < 16; i++) begin
      expect_evt(P_HIT, 2 + i, 0, (2 + i) == 17);
      fire_shot(5 + i / 10, i % 10);
      wait_idle("game_idle");
      if (i < 15) begin
        expect_evt(P_MISS, 2 + i, 0, 1'b0);
        fire_shot(7 + i / 10, i % 10);
        wait_idle("game_idle");
      end
    end
    chk("over_state", {game_over, winner, player_turn, busy}, 32'b1001);
    chk("over_hits", {hits_p1, hits_p2}, {18'd0, 7'd17, 7'd0});
    fire_shot(9, 9);
    chk("over_fire_ignored", brd_req, 32'd0);
    @(negedge clock27);
    chk("over_frozen", {hits_p1, game_over}, {24'd0, 7'd17, 1'b1});
    new_game = 1'b1;
    @(negedge clock27);
    new_game = 1'b0;
    chk("new_game_over", {hits_p1, hits_p2, game_over, winner, player_turn, busy}, 32'd0);

    // new_game from IDLE
    expect_evt(P_HIT, 1, 0, 1'b0);
    fire_shot(9, 0);
    wait_idle("ng_idle");
    new_game = 1'b1;
    @(negedge clock27);
    new_game = 1'b0;
    chk("new_game_idle", {hits_p1, hits_p2, player_turn, busy}, 32'd0);

    // Reset while waiting for a read grant
    wc = wr_count;
    brd_gnt = 1'b0;
    fire_shot(4, 4);
    chk("rst_mid_req", brd_req, 32'd1);
    reset = 1'b1;
    @(negedge clock27);
    reset = 1'b0;
    chk("rst_mid_clear", {brd_req, busy}, 32'd0);
    brd_gnt = 1'b1;
    @(negedge clock27);
    chk("rst_mid_no_write", {brd_req, 32'(wr_count - wc)}, 32'd0);

    expect_evt(P_MISS, 0, 0, 1'b0);
    fire_shot(0, 9);
    wait_idle("pre_tmo_idle");
    chk("pre_tmo_turn", player_turn, 32'd1);

`ifdef TURN_TIMEOUT_EN
    expect_evt(P_TMO, 0, 0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clock27);
      chk("tmo_early", turn_timeout, 32'd0);
    end
    @(negedge clock27);
    chk("tmo_pulse", turn_timeout, 32'd1);
    @(negedge clock27);
    chk("tmo_turn", {player_turn, busy}, 32'd0);
    repeat (7) @(negedge clock27);
    expect_evt(P_MISS, 0, 0, 1'b0);
    fire_shot(0, 8);
    wait_idle("tmo_fire_idle");
    chk("tmo_fire_turn", player_turn, 32'd1);
`else
    tmo_seen = 1'b0;
    repeat (12) begin
      @(negedge clock27);
      tmo_seen = tmo_seen | turn_timeout;
    end
    chk("no_timeout", {tmo_seen, player_turn}, 32'b01);
`endif

    repeat (2) @(negedge clock27);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
